// File: rtl/mem_block_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : mem_block_apb_master
//  Description : Requester-side bridge from a valid/ready command port to the
//                sel/enable/wr/addr/wdata bus of a mem_block register bank.
//                Each command becomes one SETUP + ACCESS transfer, with an
//                optional wait-state timeout that aborts hung transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_block_apb_master #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response port
    output logic                  rsp_valid,
    output logic                  rsp_wr,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // responder bus
    output logic                  sel,
    output logic                  enable,
    output logic                  wr,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    input  logic [DATA_WIDTH-1:0] rdata
);

    // Counter just wide enough to hold TIMEOUT; one bit when the timeout is off.
    localparam int CNT_WIDTH = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_WIDTH'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 timeout_hit;

    // The last permitted ACCESS cycle without ready aborts the transfer.
    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    // State register; async reset drops the bus to idle immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake/bus phase outputs.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        sel        = 1'b0;
        enable     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                sel        = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                sel    = 1'b1;
                enable = 1'b1;
                // ready takes priority over a simultaneous timeout
                if (ready || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, wait counter and registered response generation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        wr    <= cmd_wr;
                        addr  <= cmd_addr;
                        wdata <= cmd_wdata;
                    end
                end
                SETUP: begin
                    wait_cnt <= '0;
                end
                ACCESS: begin
                    if (ready) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= wr;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= wr ? '0 : rdata;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_wr    <= wr;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (wait_cnt != '1) begin
                        // saturate so an unbounded wait never wraps
                        wait_cnt <= wait_cnt + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_block_apb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_block_apb_master
//  Description : Self-checking bench for mem_block_apb_master with a small
//                mem_block responder model (programmable wait states / hang).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_block_apb_master;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          clk;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_wr;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          sel;
    logic          enable;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ready;
    logic [DW-1:0] rdata;

    mem_block_apb_master #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_addr (cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_wr   (rsp_wr),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .sel      (sel),
        .enable   (enable),
        .wr       (wr),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- responder model (mem_block, RESET_VAL 0) ----------------
    logic [DW-1:0] mem [256];
    int            wait_cfg;   // ACCESS cycles with ready low; -1 = never ready
    int            acc_cnt;

    assign ready = enable && (wait_cfg >= 0) && (acc_cnt >= wait_cfg);
    // garbage on rdata except on the ready cycle exposes early sampling
    assign rdata = ready ? mem[addr] : 8'hEE;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_cnt <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (enable && !ready) acc_cnt <= acc_cnt + 1;
            else                  acc_cnt <= 0;
            if (sel && enable && ready && wr) mem[addr] <= wdata;
        end
    end

    // ---------------- monitor: cycles, handshakes, response pulses ----------------
    int cyc;
    int hs_count;
    int hs_cyc [2];
    int rsp_pulses;

    initial begin
        cyc = 0; hs_count = 0; rsp_pulses = 0;
        hs_cyc[0] = 0; hs_cyc[1] = 0;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) rsp_pulses <= rsp_pulses + 1;
        if (reset_n && cmd_valid && cmd_ready) begin
            if (hs_count < 2) hs_cyc[hs_count] <= cyc;
            hs_count <= hs_count + 1;
        end
    end

    // ---------------- checking ----------------
    int errors;
    int checks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    // One complete command: handshake, SETUP/ACCESS phase checks, response checks.
    task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input logic exp_err, input logic [DW-1:0] exp_rd,
                           input string tag);
        int n;
        int acc;
        int exp_acc;
        bit bus_ok;
        exp_acc = (waits < 0) ? TO : ((waits + 1 > TO) ? TO : waits + 1);
        wait_cfg  = waits;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        #1 cmd_valid = 1'b0;
        // first cycle after the handshake edge is SETUP
        check({tag, " setup sel/en"}, {30'd0, sel, enable}, 32'b10);
        bus_ok = (wr === w) && (addr === a) && (wdata === d);
        acc = 0;
        @(negedge clk);
        while (enable && acc < 50) begin
            if (!(sel === 1'b1 && wr === w && addr === a && wdata === d)) bus_ok = 1'b0;
            if (rsp_valid !== 1'b0) bus_ok = 1'b0;
            acc++;
            @(negedge clk);
        end
        check({tag, " bus stable"}, {31'd0, bus_ok}, 32'd1);
        check({tag, " access cycles"}, acc, exp_acc);
        // first IDLE cycle carries the response pulse
        check({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, " rsp fields"}, {22'd0, rsp_wr, rsp_err, rsp_rdata},
              {22'd0, w, exp_err, exp_rd});
        check({tag, " cmd_ready idle"}, {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        check({tag, " rsp single pulse"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    vec_t vecs [10];
    int   pulses_before;
    int   n;

    initial begin
        errors = 0; checks = 0;
        wait_cfg = 0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        reset_n = 1'b0;

        vecs[0] = '{wr:1'b0, addr:8'h01, wdata:8'h00, waits:0,  exp_err:1'b0, exp_rdata:8'h00};
        vecs[1] = '{wr:1'b1, addr:8'h01, wdata:8'hAA, waits:0,  exp_err:1'b0, exp_rdata:8'h00};
        vecs[2] = '{wr:1'b0, addr:8'h01, wdata:8'h00, waits:0,  exp_err:1'b0, exp_rdata:8'hAA};
        vecs[3] = '{wr:1'b0, addr:8'h01, wdata:8'h00, waits:3,  exp_err:1'b0, exp_rdata:8'hAA};
        vecs[4] = '{wr:1'b0, addr:8'h01, wdata:8'h00, waits:-1, exp_err:1'b1, exp_rdata:8'h00};
        vecs[5] = '{wr:1'b1, addr:8'h03, wdata:8'h11, waits:-1, exp_err:1'b1, exp_rdata:8'h00};
        vecs[6] = '{wr:1'b0, addr:8'h03, wdata:8'h00, waits:0,  exp_err:1'b0, exp_rdata:8'h00};
        vecs[7] = '{wr:1'b0, addr:8'h01, wdata:8'h00, waits:2,  exp_err:1'b0, exp_rdata:8'hAA};
        vecs[8] = '{wr:1'b1, addr:8'hFF, wdata:8'h5A, waits:1,  exp_err:1'b0, exp_rdata:8'h00};
        vecs[9] = '{wr:1'b0, addr:8'hFF, wdata:8'h00, waits:3,  exp_err:1'b0, exp_rdata:8'h5A};

        // reset state
        #12;
        check("reset sel/en", {30'd0, sel, enable}, 32'd0);
        check("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("reset rsp", {21'd0, rsp_valid, rsp_wr, rsp_err, rsp_rdata}, 32'd0);
        check("reset bus regs", {15'd0, wr, addr, wdata}, 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].waits,
                    vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
        end

        // back-to-back: cmd_valid held high across two commands
        pulses_before = rsp_pulses;
        hs_count  = 0;
        wait_cfg  = 0;
        cmd_wr = 1'b1; cmd_addr = 8'h02; cmd_wdata = 8'h55;
        cmd_valid = 1'b1;
        n = 0;
        while (hs_count < 1 && n < 20) begin @(negedge clk); n++; end
        #1 cmd_wr = 1'b0; cmd_wdata = 8'h00;
        n = 0;
        while (hs_count < 2 && n < 20) begin @(negedge clk); n++; end
        #1 cmd_valid = 1'b0;
        n = 0;
        while (rsp_pulses < pulses_before + 2 && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("b2b handshakes", hs_count, 2);
        check("b2b spacing", hs_cyc[1] - hs_cyc[0], 3);
        check("b2b pulses", rsp_pulses - pulses_before, 2);
        check("b2b read data", {23'd0, rsp_wr, rsp_rdata}, {23'd0, 1'b0, 8'h55});

        // asynchronous reset in the middle of a hung ACCESS
        wait_cfg = -1;
        cmd_wr = 1'b0; cmd_addr = 8'h01; cmd_valid = 1'b1;
        n = 0;
        while (!enable && n < 20) begin @(negedge clk); n++; end
        #1 cmd_valid = 1'b0;
        check("pre-reset in access", {30'd0, sel, enable}, 32'b11);
        pulses_before = rsp_pulses;
        #2 reset_n = 1'b0;
        #1;
        check("async reset sel/en", {30'd0, sel, enable}, 32'd0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no rsp after reset", rsp_pulses - pulses_before, 0);
        check("cmd_ready after reset", {31'd0, cmd_ready}, 32'd1);
        run_cmd(1'b0, 8'h01, 8'h00, 0, 1'b0, 8'h00, "post-reset read");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // hard stop so the bench can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
